// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared types and defaults for the instruction-fetch sequencer.
//   - DEFAULT_* : reset PC, instruction memory base/depth and fetch-queue depth
//   - fetch_state_t : sequencer FSM states
//   - fetch_entry_t : one fetched word tagged with its byte address
//   - pc_is_legal : address check applied before every fetch request
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0004_0000;
    localparam logic [31:0] DEFAULT_MEM_BASE    = 32'h0004_0000;
    localparam int          DEFAULT_MEM_DEPTH   = 101;
    localparam int          DEFAULT_QUEUE_DEPTH = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // A PC is fetchable when it is word aligned and lands inside the memory.
    // The subtraction wraps for pc < base, so the explicit lower-bound test is needed.
    function automatic logic pc_is_legal(input logic [31:0] pc,
                                         input logic [31:0] base,
                                         input logic [31:0] depth);
        logic [31:0] word_idx;
        word_idx = (pc - base) >> 2;
        return (pc[1:0] == 2'b00) && (pc >= base) && (word_idx < depth);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Bundles the redirect, instruction-memory and decode-side signals of the
//   fetch sequencer.
//   - redirect_valid/redirect_pc : restart request from branch resolution
//   - imem_req/imem_addr         : word request to instruction memory
//   - imem_rvalid/imem_rdata     : memory response
//   - instr_valid/instr_ready/instr/instr_pc : queue head towards decode
//   - fault/fault_pc             : sticky illegal-PC indication
//   master : the fetch sequencer side
//   slave  : the surrounding environment (branch unit, memory, decode)
interface fetch_sequencer_if;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fault;
    logic [31:0] fault_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_rvalid, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc, fault, fault_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_rvalid, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, fault, fault_pc
    );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
//   Small FIFO of fetch_entry_t between the memory response and decode.
//   Ports:
//   - clk, rst        : clock, asynchronous active-high reset
//   - push, push_data : write one entry
//   - pop             : consume the head entry (ignored when empty)
//   - flush           : discard every entry; wins over push/pop in the same cycle
//   - head            : current oldest entry
//   - count           : number of stored entries
//   - full, empty     : occupancy flags
//   DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    fetch_entry_t     storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full queue is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign head    = storage[rd_ptr];

    // Pointer, occupancy and storage update; flush simply rewinds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                storage[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the program counter, issues one instruction-memory request at a time,
//   queues returned words with their PCs for decode, handles branch redirects
//   (flushing queued and in-flight work) and raises a sticky fault on an
//   illegal PC.
//   Ports:
//   - clk : rising-edge clock
//   - rst : asynchronous active-high reset
//   - bus : fetch_sequencer_if.master (redirect, imem request/response,
//           decode valid/ready/instr/instr_pc, fault/fault_pc)
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter logic [31:0] MEM_BASE    = DEFAULT_MEM_BASE,
    parameter int          MEM_DEPTH   = DEFAULT_MEM_DEPTH,
    parameter int          QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.master  bus
);

    localparam int             CNT_W        = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(QUEUE_DEPTH);

    fetch_state_t     state;
    logic [31:0]      pc;
    logic [31:0]      req_pc;
    logic             drop;
    logic             fault_q;
    logic [31:0]      fault_pc_q;

    fetch_entry_t     q_head;
    fetch_entry_t     push_entry;
    logic [CNT_W-1:0] q_count;
    logic             q_full;
    logic             q_empty;

    logic             pop;
    logic             push;
    logic [CNT_W:0]   count_after;
    logic             pc_legal;
    logic [31:0]      word_idx;
    logic             attempt;
    logic             issue;
    logic             fault_hit;

    // Issue decision. The request strobe is decided combinationally from the
    // registered state so that a response and the next request can share a
    // cycle, giving one word per cycle with single-cycle memory. Credit counts
    // the pop and push happening this cycle so the queue can never overflow.
    always_comb begin
        pop         = !q_empty && bus.instr_ready;
        push        = (state == WAIT) && bus.imem_rvalid && !bus.redirect_valid
                      && (!q_full || pop);
        count_after = {1'b0, q_count} + {{CNT_W{1'b0}}, push} - {{CNT_W{1'b0}}, pop};
        pc_legal    = pc_is_legal(pc, MEM_BASE, 32'(MEM_DEPTH));
        word_idx    = (pc - MEM_BASE) >> 2;
        attempt     = !rst && !bus.redirect_valid && (count_after < CREDIT_LIMIT)
                      && (((state == RUN) && !drop) || ((state == WAIT) && bus.imem_rvalid));
        issue       = attempt && pc_legal;
        fault_hit   = attempt && !pc_legal;
    end

    // Sequencer FSM. A redirect overrides everything: the PC is reloaded, the
    // fault is cleared and any request still in flight is marked for dropping
    // so its late response cannot enter the new instruction stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            pc         <= RESET_PC;
            req_pc     <= '0;
            drop       <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else if (bus.redirect_valid) begin
            state   <= RUN;
            pc      <= bus.redirect_pc;
            fault_q <= 1'b0;
            drop    <= ((state == WAIT) || drop) && !bus.imem_rvalid;
        end else begin
            if (drop && bus.imem_rvalid) begin
                drop <= 1'b0;
            end
            case (state)
                RUN, WAIT: begin
                    if (issue) begin
                        pc     <= pc + 32'd4;
                        req_pc <= pc;
                        state  <= WAIT;
                    end else if (fault_hit) begin
                        fault_q    <= 1'b1;
                        fault_pc_q <= pc;
                        state      <= FAULT;
                    end else if ((state == WAIT) && bus.imem_rvalid) begin
                        state <= RUN;
                    end
                end
                FAULT:   state <= FAULT;
                default: state <= RUN;
            endcase
        end
    end

    assign push_entry = '{pc: req_pc, instr: bus.imem_rdata};

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Head data is forced to zero while the queue is empty so stale entries
    // never appear on the decode bus.
    assign bus.imem_req    = issue;
    assign bus.imem_addr   = issue ? word_idx : '0;
    assign bus.instr_valid = !q_empty;
    assign bus.instr       = q_empty ? '0 : q_head.instr;
    assign bus.instr_pc    = q_empty ? '0 : q_head.pc;
    assign bus.fault       = fault_q;
    assign bus.fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Self-checking bench for fetch_sequencer: a table of per-cycle vectors for
//   streaming and back-pressure, then hand-written sequences for redirects,
//   the end-of-memory fault, a misaligned redirect and reset mid-request.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam logic [31:0] BASE = 32'h0004_0000;

    typedef struct {
        bit          do_reset;
        bit          ready;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_sequencer_if bus();

    fetch_sequencer #(
        .RESET_PC    (32'h0004_0000),
        .MEM_BASE    (32'h0004_0000),
        .MEM_DEPTH   (101),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          mem_lat  = 1;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr_q;
    vec_t        vecs[$];

    function automatic logic [31:0] mem_word(input logic [31:0] idx);
        return (idx * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    // Instruction memory model with a programmable latency in cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.imem_rvalid <= 1'b0;
            bus.imem_rdata  <= '0;
            mem_busy        <= 1'b0;
            mem_cnt         <= 0;
            mem_addr_q      <= '0;
        end else begin
            bus.imem_rvalid <= 1'b0;
            if (mem_busy) begin
                if (mem_cnt <= 1) begin
                    bus.imem_rvalid <= 1'b1;
                    bus.imem_rdata  <= mem_word(mem_addr_q);
                    mem_busy        <= 1'b0;
                end else begin
                    mem_cnt <= mem_cnt - 1;
                end
            end
            if (bus.imem_req) begin
                if (mem_lat <= 1) begin
                    bus.imem_rvalid <= 1'b1;
                    bus.imem_rdata  <= mem_word(bus.imem_addr);
                end else begin
                    mem_busy   <= 1'b1;
                    mem_addr_q <= bus.imem_addr;
                    mem_cnt    <= mem_lat - 1;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " imem_req"},    {31'b0, bus.imem_req},    32'd0);
        checkOutput({tag, " imem_addr"},   bus.imem_addr,            32'd0);
        checkOutput({tag, " instr_valid"}, {31'b0, bus.instr_valid}, 32'd0);
        checkOutput({tag, " instr"},       bus.instr,                32'd0);
        checkOutput({tag, " instr_pc"},    bus.instr_pc,             32'd0);
        checkOutput({tag, " fault"},       {31'b0, bus.fault},       32'd0);
        checkOutput({tag, " fault_pc"},    bus.fault_pc,             32'd0);
    endtask

    // Holds reset for one cycle, checks outputs while it is held, and returns
    // at the negedge where reset is released (the first live cycle).
    task automatic doReset(input bit ready_at_release);
        @(negedge clk);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;
        bus.instr_ready = ready_at_release;
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        if (v.do_reset) begin
            doReset(v.ready);
        end else begin
            @(negedge clk);
            bus.instr_ready = v.ready;
        end
        #1;
        checkOutput($sformatf("vec%0d imem_req", idx), {31'b0, bus.imem_req}, {31'b0, v.exp_req});
        if (v.exp_req)
            checkOutput($sformatf("vec%0d imem_addr", idx), bus.imem_addr, v.exp_addr);
        checkOutput($sformatf("vec%0d instr_valid", idx), {31'b0, bus.instr_valid}, {31'b0, v.exp_valid});
        if (v.exp_valid) begin
            checkOutput($sformatf("vec%0d instr_pc", idx), bus.instr_pc, v.exp_pc);
            checkOutput($sformatf("vec%0d instr", idx), bus.instr, mem_word((v.exp_pc - BASE) >> 2));
        end
    endtask

    function automatic void addVec(input bit r, input bit rdy, input bit req,
                                   input logic [31:0] addr, input bit vld, input logic [31:0] vpc);
        vec_t v;
        v.do_reset  = r;
        v.ready     = rdy;
        v.exp_req   = req;
        v.exp_addr  = addr;
        v.exp_valid = vld;
        v.exp_pc    = vpc;
        vecs.push_back(v);
    endfunction

    initial begin
        bit          seen;
        logic [31:0] seen_addr;
        logic [31:0] exp_pc;
        int          reqs;
        int          stray;
        logic [31:0] last_addr;

        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;

        // Streaming with ready=1 after reset release.
        addVec(1, 1, 1, 0, 0, 0);
        addVec(0, 1, 1, 1, 0, 0);
        addVec(0, 1, 1, 2, 1, 32'h0004_0000);
        addVec(0, 1, 1, 3, 1, 32'h0004_0004);
        addVec(0, 1, 1, 4, 1, 32'h0004_0008);
        addVec(0, 1, 1, 5, 1, 32'h0004_000C);
        // Decode stalled for 10 cycles: only two requests, then in-order drain.
        addVec(1, 0, 1, 0, 0, 0);
        addVec(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) addVec(0, 0, 0, 0, 1, 32'h0004_0000);
        addVec(0, 1, 1, 2, 1, 32'h0004_0000);
        addVec(0, 1, 1, 3, 1, 32'h0004_0004);
        addVec(0, 1, 1, 4, 1, 32'h0004_0008);
        addVec(0, 1, 1, 5, 1, 32'h0004_000C);

        mem_lat = 1;
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        // Redirect while a 3-cycle request is outstanding: stale word dropped.
        mem_lat = 3;
        doReset(1'b1);
        #1;
        checkOutput("slow first req", {31'b0, bus.imem_req}, 32'd1);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0004_0020;
        #1;
        checkOutput("slow redirect cycle req", {31'b0, bus.imem_req}, 32'd0);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        seen = 1'b0;
        seen_addr = '0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.imem_req) begin
                seen = 1'b1;
                seen_addr = bus.imem_addr;
            end else begin
                nextCycle();
            end
        end
        checkOutput("slow redirect req seen", {31'b0, seen}, 32'd1);
        checkOutput("slow redirect addr", seen_addr, 32'd8);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            nextCycle();
            seen = bus.instr_valid;
        end
        checkOutput("slow redirect valid seen", {31'b0, seen}, 32'd1);
        checkOutput("slow redirect instr_pc", bus.instr_pc, 32'h0004_0020);
        checkOutput("slow redirect instr", bus.instr, mem_word(32'd8));

        // Redirect coincident with a response and a decode pop.
        mem_lat = 1;
        doReset(1'b1);
        @(negedge clk);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0004_0040;
        #1;
        checkOutput("coinc popped valid", {31'b0, bus.instr_valid}, 32'd1);
        checkOutput("coinc popped pc", bus.instr_pc, 32'h0004_0000);
        checkOutput("coinc redirect req", {31'b0, bus.imem_req}, 32'd0);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        checkOutput("coinc queue empty", {31'b0, bus.instr_valid}, 32'd0);
        checkOutput("coinc new req", {31'b0, bus.imem_req}, 32'd1);
        checkOutput("coinc new addr", bus.imem_addr, 32'd16);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            nextCycle();
            seen = bus.instr_valid;
        end
        checkOutput("coinc first pc", bus.instr_pc, 32'h0004_0040);

        // Run off the end of memory: fault at the PC after word 100.
        doReset(1'b1);
        #1;
        exp_pc = 32'h0004_0000;
        reqs = 0;
        last_addr = '0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (bus.imem_req) begin
                reqs++;
                last_addr = bus.imem_addr;
            end
            if (bus.instr_valid) begin
                checkOutput("drain instr_pc", bus.instr_pc, exp_pc);
                checkOutput("drain instr", bus.instr, mem_word((exp_pc - BASE) >> 2));
                exp_pc = exp_pc + 32'd4;
            end
            seen = bus.fault;
            if (!seen) nextCycle();
        end
        checkOutput("end fault seen", {31'b0, seen}, 32'd1);
        checkOutput("end fault_pc", bus.fault_pc, 32'h0004_0194);
        checkOutput("end request count", 32'(reqs), 32'd101);
        checkOutput("end last addr", last_addr, 32'd100);
        checkOutput("end delivered through", exp_pc, 32'h0004_0194);
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            if (bus.imem_req) stray++;
        end
        checkOutput("fault no requests", 32'(stray), 32'd0);
        checkOutput("fault sticky", {31'b0, bus.fault}, 32'd1);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0004_0000;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        checkOutput("resume fault cleared", {31'b0, bus.fault}, 32'd0);
        checkOutput("resume req", {31'b0, bus.imem_req}, 32'd1);
        checkOutput("resume addr", bus.imem_addr, 32'd0);

        // Misaligned redirect faults without issuing.
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0004_0002;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        stray = 0;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (bus.imem_req) stray++;
            seen = bus.fault;
            if (!seen) nextCycle();
        end
        checkOutput("misaligned fault", {31'b0, seen}, 32'd1);
        checkOutput("misaligned fault_pc", bus.fault_pc, 32'h0004_0002);
        checkOutput("misaligned no req", 32'(stray), 32'd0);

        // Reset asserted while a request is outstanding and the queue holds data.
        mem_lat = 3;
        bus.instr_ready = 1'b0;
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0004_0000;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            nextCycle();
            seen = bus.instr_valid;
        end
        checkOutput("midwait valid before reset", {31'b0, seen}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkAllZero("midwait reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post reset req", {31'b0, bus.imem_req}, 32'd1);
        checkOutput("post reset addr", bus.imem_addr, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
